// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder
// Word-addressed RAM that answers the riscv_core instruction and data ports
// with fixed response latency, periodic accept throttling, address-range
// error generation, fetch flush and a backdoor preload port. Three counters
// report accepted fetches, data reads and data writes.
module riscv_mem_responder #(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int unsigned I_LATENCY    = 1,
    parameter int unsigned D_LATENCY    = 1,
    parameter int unsigned I_ACCEPT_GAP = 0,
    parameter int unsigned D_ACCEPT_GAP = 0,
    parameter int unsigned TAG_W        = 11
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          mem_i_rd_i,
    input  logic                          mem_i_flush_i,
    input  logic                          mem_i_invalidate_i,
    input  logic [31:0]                   mem_i_pc_i,
    output logic                          mem_i_accept_o,
    output logic                          mem_i_valid_o,
    output logic                          mem_i_error_o,
    output logic [31:0]                   mem_i_inst_o,
    input  logic [31:0]                   mem_d_addr_i,
    input  logic [31:0]                   mem_d_data_wr_i,
    input  logic                          mem_d_rd_i,
    input  logic [3:0]                    mem_d_wr_i,
    input  logic                          mem_d_cacheable_i,
    input  logic [TAG_W-1:0]              mem_d_req_tag_i,
    input  logic                          mem_d_invalidate_i,
    input  logic                          mem_d_writeback_i,
    input  logic                          mem_d_flush_i,
    output logic                          mem_d_accept_o,
    output logic                          mem_d_ack_o,
    output logic                          mem_d_error_o,
    output logic [31:0]                   mem_d_data_rd_o,
    output logic [TAG_W-1:0]              mem_d_resp_tag_o,
    input  logic                          load_en_i,
    input  logic [$clog2(MEM_WORDS)-1:0]  load_addr_i,
    input  logic [31:0]                   load_data_i,
    output logic [31:0]                   cnt_ifetch_o,
    output logic [31:0]                   cnt_drd_o,
    output logic [31:0]                   cnt_dwr_o
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [31:0]      i_gap_q, i_gap_d, d_gap_q, d_gap_d;
    logic [31:0]      cnt_ifetch_q, cnt_ifetch_d, cnt_drd_q, cnt_drd_d, cnt_dwr_q, cnt_dwr_d;
    logic             i_take_s, i_ok_s;
    logic [31:0]      i_off_s, i_word_s;
    logic [AW-1:0]    i_idx_s;
    logic             d_wr_any_s, d_req_s, d_take_s, d_ok_s, d_err_s, d_wen_s;
    logic [31:0]      d_off_s, d_rdata_s;
    logic [AW-1:0]    d_idx_s;
    logic             i_vld_q [I_LATENCY];
    logic             i_err_q [I_LATENCY];
    logic [31:0]      i_dat_q [I_LATENCY];
    logic             d_vld_q [D_LATENCY];
    logic             d_err_q [D_LATENCY];
    logic [31:0]      d_dat_q [D_LATENCY];
    logic [TAG_W-1:0] d_tag_q [D_LATENCY];
    logic             unused_s;

    // Accept depends on rst_i directly so it is low throughout reset and
    // high in the very first cycle after release (gap counter is then 0).
    assign mem_i_accept_o = ~rst_i & ~((I_ACCEPT_GAP != 32'd0) && (i_gap_q == I_ACCEPT_GAP));
    assign mem_d_accept_o = ~rst_i & ~((D_ACCEPT_GAP != 32'd0) && (d_gap_q == D_ACCEPT_GAP));

    // Free-running gap counters wrap at their GAP value; accepted-request counters.
    always_comb begin
        i_gap_d      = (i_gap_q >= I_ACCEPT_GAP) ? 32'd0 : i_gap_q + 32'd1;
        d_gap_d      = (d_gap_q >= D_ACCEPT_GAP) ? 32'd0 : d_gap_q + 32'd1;
        cnt_ifetch_d = cnt_ifetch_q + {31'd0, i_take_s};
        cnt_drd_d    = cnt_drd_q + {31'd0, d_take_s & mem_d_rd_i};
        cnt_dwr_d    = cnt_dwr_q + {31'd0, d_take_s & d_wr_any_s};
    end

    // Fetch decode: range/alignment check and same-cycle RAM read (pre-write value).
    always_comb begin
        i_take_s = mem_i_rd_i & mem_i_accept_o;
        i_off_s  = mem_i_pc_i - BASE_ADDR;
        i_idx_s  = i_off_s[AW+1:2];
        i_ok_s   = (mem_i_pc_i >= BASE_ADDR) && (i_off_s[31:AW+2] == {(30-AW){1'b0}})
                   && (mem_i_pc_i[1:0] == 2'b00);
        i_word_s = i_ok_s ? mem_q[i_idx_s] : 32'd0;
    end

    // Data decode: maintenance-only requests never error; rd+wr together always errors.
    always_comb begin
        d_wr_any_s = |mem_d_wr_i;
        d_req_s    = mem_d_rd_i | d_wr_any_s | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
        d_take_s   = d_req_s & mem_d_accept_o;
        d_off_s    = mem_d_addr_i - BASE_ADDR;
        d_idx_s    = d_off_s[AW+1:2];
        d_ok_s     = (mem_d_addr_i >= BASE_ADDR) && (d_off_s[31:AW+2] == {(30-AW){1'b0}})
                     && (mem_d_addr_i[1:0] == 2'b00);
        d_err_s    = (mem_d_rd_i & d_wr_any_s) | ((mem_d_rd_i | d_wr_any_s) & ~d_ok_s);
        d_wen_s    = d_take_s & d_wr_any_s & ~d_err_s;
        d_rdata_s  = (mem_d_rd_i & ~d_err_s) ? mem_q[d_idx_s] : 32'd0;
    end

    // Gap and access counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_gap_q      <= 32'd0;
            d_gap_q      <= 32'd0;
            cnt_ifetch_q <= 32'd0;
            cnt_drd_q    <= 32'd0;
            cnt_dwr_q    <= 32'd0;
        end else begin
            i_gap_q      <= i_gap_d;
            d_gap_q      <= d_gap_d;
            cnt_ifetch_q <= cnt_ifetch_d;
            cnt_drd_q    <= cnt_drd_d;
            cnt_dwr_q    <= cnt_dwr_d;
        end
    end

    // RAM: data-port byte writes, then backdoor load so load wins on the same word.
    always_ff @(posedge clk_i) begin
        if (d_wen_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_d_wr_i[b]) begin
                    mem_q[d_idx_s][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
                end
            end
        end
        if (load_en_i) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    // Fetch latency pipeline; flush kills every stage including the fetch taken now.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(I_LATENCY); s++) begin
                i_vld_q[s] <= 1'b0;
                i_err_q[s] <= 1'b0;
                i_dat_q[s] <= 32'd0;
            end
        end else begin
            i_vld_q[0] <= i_take_s & ~mem_i_flush_i;
            i_err_q[0] <= i_take_s & ~i_ok_s & ~mem_i_flush_i;
            i_dat_q[0] <= (i_take_s & ~mem_i_flush_i) ? i_word_s : 32'd0;
            for (int s = 1; s < int'(I_LATENCY); s++) begin
                i_vld_q[s] <= i_vld_q[s-1] & ~mem_i_flush_i;
                i_err_q[s] <= i_err_q[s-1] & ~mem_i_flush_i;
                i_dat_q[s] <= mem_i_flush_i ? 32'd0 : i_dat_q[s-1];
            end
        end
    end

    // Data latency pipeline carrying error, read data and tag with each request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(D_LATENCY); s++) begin
                d_vld_q[s] <= 1'b0;
                d_err_q[s] <= 1'b0;
                d_dat_q[s] <= 32'd0;
                d_tag_q[s] <= {TAG_W{1'b0}};
            end
        end else begin
            d_vld_q[0] <= d_take_s;
            d_err_q[0] <= d_take_s & d_err_s;
            d_dat_q[0] <= d_take_s ? d_rdata_s : 32'd0;
            d_tag_q[0] <= d_take_s ? mem_d_req_tag_i : {TAG_W{1'b0}};
            for (int s = 1; s < int'(D_LATENCY); s++) begin
                d_vld_q[s] <= d_vld_q[s-1];
                d_err_q[s] <= d_err_q[s-1];
                d_dat_q[s] <= d_dat_q[s-1];
                d_tag_q[s] <= d_tag_q[s-1];
            end
        end
    end

    assign mem_i_valid_o    = i_vld_q[I_LATENCY-1];
    assign mem_i_error_o    = i_err_q[I_LATENCY-1];
    assign mem_i_inst_o     = i_dat_q[I_LATENCY-1];
    assign mem_d_ack_o      = d_vld_q[D_LATENCY-1];
    assign mem_d_error_o    = d_err_q[D_LATENCY-1];
    assign mem_d_data_rd_o  = d_dat_q[D_LATENCY-1];
    assign mem_d_resp_tag_o = d_tag_q[D_LATENCY-1];
    assign cnt_ifetch_o     = cnt_ifetch_q;
    assign cnt_drd_o        = cnt_drd_q;
    assign cnt_dwr_o        = cnt_dwr_q;

    // Inputs with no functional effect, and offset bits covered by the alignment check.
    assign unused_s = ^{mem_i_invalidate_i, mem_d_cacheable_i, i_off_s[1:0], d_off_s[1:0]};

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Bench for riscv_mem_responder: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_riscv_mem_responder;
    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          IL   = 3;
    localparam int          DL   = 4;
    localparam int          IG   = 2;
    localparam int          DG   = 1;
    localparam int          TW   = 11;

    logic          clk_i = 1'b0;
    logic          rst_i, mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
    logic [31:0]   mem_i_pc_i, mem_d_addr_i, mem_d_data_wr_i, load_data_i;
    logic          mem_d_rd_i, mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
    logic [3:0]    mem_d_wr_i;
    logic [TW-1:0] mem_d_req_tag_i;
    logic          load_en_i;
    logic [5:0]    load_addr_i;
    logic          mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [31:0]   mem_i_inst_o, mem_d_data_rd_o, cnt_ifetch_o, cnt_drd_o, cnt_dwr_o;
    logic          mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [TW-1:0] mem_d_resp_tag_o;

    riscv_mem_responder #(
        .MEM_WORDS(MW), .BASE_ADDR(BASE), .I_LATENCY(IL), .D_LATENCY(DL),
        .I_ACCEPT_GAP(IG), .D_ACCEPT_GAP(DG), .TAG_W(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
        .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
        .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
        .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_accept_o(mem_d_accept_o),
        .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
        .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_resp_tag_o(mem_d_resp_tag_o),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .cnt_ifetch_o(cnt_ifetch_o), .cnt_drd_o(cnt_drd_o), .cnt_dwr_o(cnt_dwr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            due;
        bit            err;
        bit [31:0]     data;
        bit [TW-1:0]   tag;
    } rsp_t;

    rsp_t        iq[$];
    rsp_t        dq[$];
    bit [31:0]   ref_mem [MW];
    int          cyc = 0;
    int          tr = 0;
    bit          known = 1'b0;
    int unsigned m_if = 0, m_rd = 0, m_wr = 0;
    int          n_chk = 0, n_bad = 0;
    bit          last_i_take, last_d_take;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Accept is low in the last cycle of every (gap+1)-cycle window after reset release.
    function automatic bit acc_exp(input int gap);
        return (rst_i == 1'b0) && ((gap == 0) || ((tr % (gap + 1)) != gap));
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < MW) && (a % 4 == 0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 15));
        if (k == 0)      return BASE - 32'(4 * $urandom_range(1, 4));
        else if (k == 1) return BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 3));
        else if (k == 2) return BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(1, 3));
        else             return BASE + 32'(4 * $urandom_range(0, MW - 1));
    endfunction

    task automatic model_update();
        bit ai, ad, wr_any;
        rsp_t r;
        ai = acc_exp(IG);
        ad = acc_exp(DG);
        last_i_take = 1'b0;
        last_d_take = 1'b0;
        if (rst_i) begin
            iq.delete();
            dq.delete();
            m_if = 0; m_rd = 0; m_wr = 0;
            tr = 0;
            known = 1'b1;
        end else begin
            tr++;
            if (mem_i_flush_i) iq.delete();
            if (mem_i_rd_i && ai) begin
                last_i_take = 1'b1;
                m_if++;
                if (!mem_i_flush_i) begin
                    r.due = cyc + IL;
                    r.err = !addr_ok(mem_i_pc_i);
                    r.data = r.err ? 32'd0 : ref_mem[word_of(mem_i_pc_i)];
                    r.tag = '0;
                    iq.push_back(r);
                end
            end
            wr_any = (mem_d_wr_i != 4'd0);
            if ((mem_d_rd_i || wr_any || mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i) && ad) begin
                last_d_take = 1'b1;
                r.due = cyc + DL;
                r.tag = mem_d_req_tag_i;
                r.err = 1'b0;
                r.data = 32'd0;
                if (mem_d_rd_i) m_rd++;
                if (wr_any) m_wr++;
                if (mem_d_rd_i && wr_any) r.err = 1'b1;
                else if ((mem_d_rd_i || wr_any) && !addr_ok(mem_d_addr_i)) r.err = 1'b1;
                else if (mem_d_rd_i) r.data = ref_mem[word_of(mem_d_addr_i)];
                else if (wr_any) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_d_wr_i[b]) ref_mem[word_of(mem_d_addr_i)][8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
                end
                dq.push_back(r);
            end
        end
        if (load_en_i) ref_mem[load_addr_i] = load_data_i;
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, move past the edge.
    task automatic step();
        bit ev;
        @(negedge clk_i);
        if (known) begin
            check_eq("i_accept", 64'(mem_i_accept_o), 64'(acc_exp(IG)));
            check_eq("d_accept", 64'(mem_d_accept_o), 64'(acc_exp(DG)));
            ev = (iq.size() > 0) && (iq[0].due == cyc);
            check_eq("i_valid", 64'(mem_i_valid_o), 64'(ev));
            if (ev) begin
                check_eq("i_error", 64'(mem_i_error_o), 64'(iq[0].err));
                check_eq("i_inst", 64'(mem_i_inst_o), 64'(iq[0].data));
                void'(iq.pop_front());
            end
            ev = (dq.size() > 0) && (dq[0].due == cyc);
            check_eq("d_ack", 64'(mem_d_ack_o), 64'(ev));
            if (ev) begin
                check_eq("d_error", 64'(mem_d_error_o), 64'(dq[0].err));
                check_eq("d_data", 64'(mem_d_data_rd_o), 64'(dq[0].data));
                check_eq("d_tag", 64'(mem_d_resp_tag_o), 64'(dq[0].tag));
                void'(dq.pop_front());
            end
            check_eq("cnt_ifetch", 64'(cnt_ifetch_o), 64'(m_if));
            check_eq("cnt_drd", 64'(cnt_drd_o), 64'(m_rd));
            check_eq("cnt_dwr", 64'(cnt_dwr_o), 64'(m_wr));
        end
        model_update();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        mem_i_rd_i = 1'b0; mem_i_flush_i = 1'b0; mem_i_invalidate_i = 1'b0;
        mem_d_rd_i = 1'b0; mem_d_wr_i = 4'd0; mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i = 1'b0; mem_d_flush_i = 1'b0; mem_d_cacheable_i = 1'b0;
        load_en_i = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int k = 0; k < n; k++) step();
    endtask

    // Issue one data request in the next cycle the port accepts it.
    task automatic d_op(input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [TW-1:0] tag);
        set_idle();
        while (!acc_exp(DG)) step();
        mem_d_rd_i = rd; mem_d_wr_i = wr; mem_d_addr_i = addr;
        mem_d_data_wr_i = data; mem_d_req_tag_i = tag;
        step();
        set_idle();
    endtask

    initial begin
        logic [31:0] pc;
        int          kind;
        set_idle();
        rst_i = 1'b1;
        mem_i_pc_i = BASE; mem_d_addr_i = BASE; mem_d_data_wr_i = 32'd0;
        mem_d_req_tag_i = '0; load_addr_i = 6'd0; load_data_i = 32'd0;
        @(posedge clk_i);
        #1;
        // Preload the whole RAM through the backdoor while reset is held.
        for (int w = 0; w < MW; w++) begin
            load_en_i = 1'b1;
            load_addr_i = 6'(w);
            case (w)
                0: load_data_i = 32'h0000_0013;
                1: load_data_i = 32'h0010_0093;
                2: load_data_i = 32'h0020_8113;
                3: load_data_i = 32'h0000_006F;
                4, 5, 6, 7: load_data_i = 32'd0;
                default: load_data_i = $urandom;
            endcase
            step();
        end
        idle(2);
        rst_i = 1'b0;

        // Back-to-back fetches from BASE: gap pattern gives 4 accepts in 6 cycles.
        pc = BASE;
        for (int k = 0; k < 6; k++) begin
            mem_i_rd_i = 1'b1; mem_i_pc_i = pc;
            step();
            if (last_i_take) pc = pc + 32'd4;
        end
        check_eq("ifetch_after_4", 64'(cnt_ifetch_o), 64'd4);
        idle(IL + 2);

        // Masked write then tagged read.
        d_op(1'b0, 4'b0011, 32'h0000_2010, 32'hDEAD_BEEF, 11'h000);
        d_op(1'b1, 4'b0000, 32'h0000_2010, 32'd0, 11'h5A5);
        idle(DL + 1);

        // Error cases: below base, past end, rd+wr together, misaligned write.
        while (!acc_exp(IG)) step();
        mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h0000_1FFC;
        step();
        set_idle();
        d_op(1'b1, 4'b0000, BASE + 32'(4 * MW), 32'd0, 11'h011);
        d_op(1'b1, 4'b1111, BASE + 32'd4, 32'hFFFF_FFFF, 11'h022);
        d_op(1'b1, 4'b0000, BASE + 32'd4, 32'd0, 11'h033);
        d_op(1'b0, 4'b1111, BASE + 32'd2, 32'h1234_5678, 11'h044);
        d_op(1'b0, 4'b0000, BASE, 32'd0, 11'h000);
        mem_d_writeback_i = 1'b1;
        while (!acc_exp(DG)) step();
        step();
        idle(DL + 1);

        // Flush with fetches in flight, then keep fetching afterwards.
        for (int k = 0; k < 8; k++) begin
            mem_i_rd_i = 1'b1; mem_i_pc_i = BASE + 32'(4 * k);
            mem_i_flush_i = (k == 3);
            step();
        end
        idle(IL + 2);

        // Same-cycle conflicts: fetch vs data write, backdoor load vs data write.
        set_idle();
        while (!(acc_exp(IG) && acc_exp(DG))) step();
        mem_i_rd_i = 1'b1; mem_i_pc_i = BASE + 32'h20;
        mem_d_wr_i = 4'hF; mem_d_addr_i = BASE + 32'h20; mem_d_data_wr_i = 32'h1122_3344;
        step();
        set_idle();
        while (!acc_exp(DG)) step();
        mem_d_wr_i = 4'hF; mem_d_addr_i = BASE + 32'h24; mem_d_data_wr_i = 32'hAAAA_5555;
        load_en_i = 1'b1; load_addr_i = 6'd9; load_data_i = 32'h0BAD_F00D;
        step();
        d_op(1'b1, 4'b0000, BASE + 32'h20, 32'd0, 11'h101);
        d_op(1'b1, 4'b0000, BASE + 32'h24, 32'd0, 11'h102);
        idle(DL + 1);

        // Reset with two data reads in flight; RAM contents must survive.
        d_op(1'b1, 4'b0000, BASE + 32'h8, 32'd0, 11'h201);
        d_op(1'b1, 4'b0000, BASE + 32'hC, 32'd0, 11'h202);
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        d_op(1'b1, 4'b0000, BASE + 32'h8, 32'd0, 11'h203);
        idle(DL + 1);

        // Random traffic on both ports, with occasional flush, load and reset.
        for (int k = 0; k < 1500; k++) begin
            rst_i = ($urandom_range(0, 399) == 0);
            mem_i_rd_i = ($urandom_range(0, 3) != 0);
            mem_i_pc_i = rand_addr();
            mem_i_flush_i = ($urandom_range(0, 19) == 0);
            mem_i_invalidate_i = ($urandom_range(0, 7) == 0);
            mem_d_cacheable_i = ($urandom_range(0, 1) == 0);
            mem_d_addr_i = rand_addr();
            mem_d_data_wr_i = $urandom;
            mem_d_req_tag_i = TW'($urandom);
            kind = int'($urandom_range(0, 9));
            mem_d_rd_i = (kind <= 3) || (kind == 8);
            mem_d_wr_i = ((kind >= 4 && kind <= 6) || kind == 8) ? 4'($urandom_range(1, 15)) : 4'd0;
            mem_d_invalidate_i = (kind == 7) && ($urandom_range(0, 1) == 0);
            mem_d_writeback_i = (kind == 7) && ($urandom_range(0, 1) == 0);
            mem_d_flush_i = (kind == 7) && !mem_d_invalidate_i && !mem_d_writeback_i;
            load_en_i = ($urandom_range(0, 9) == 0);
            load_addr_i = 6'($urandom_range(0, MW - 1));
            load_data_i = $urandom;
            step();
        end
        rst_i = 1'b0;
        idle(IL + DL + 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
